// File: rtl/load_store_unit_if.sv
// Request, response and RAM signals of the load/store unit, bundled so that
// the core, the LSU and the RAM share one set of nets.
//   req_*  : core -> LSU access request (valid/ready handshake)
//   rsp_*  : LSU -> core completion pulse with formatted load data / error flag
//   mem_*  : LSU <-> RAM byte-addressed word port (read strobe, write mask)
// Modports: slave = the LSU itself, master = the core/RAM side driving it.
interface load_store_unit_if #(
    parameter int XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic            req_we;
    logic [2:0]      req_funct3;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;

    logic            rsp_valid;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    logic [XLEN-1:0] mem_addr;
    logic            mem_rstrb;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] mem_wdata;
    logic [3:0]      mem_wmask;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_rstrb, mem_wdata, mem_wmask
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_rstrb, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: takes one byte/half/word access at a time from the
// core, drives a one-cycle RAM strobe or byte-masked write, and returns a
// one-cycle response carrying the sign/zero-extended load data.
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous, active-high
//   bus   - load_store_unit_if.slave (req_*, rsp_*, mem_*)
// Optional feature: define LSU_MISALIGN_TRAP_EN to flag misaligned H/W
// accesses with rsp_err instead of silently aligning them.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// ISSUE | mem_* strobes/mask presented to RAM for this single cycle
// WAIT  | RAM word on mem_rdata, formatted into rsp_rdata
// RESP  | rsp_valid pulse to the core
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    load_store_unit_if.slave        bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state;
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [3:0]      st_mask;
    logic [XLEN-1:0] st_data;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_fmt;
    logic            mis_req;
    logic            mis_q;

    // Ready is dropped combinationally during reset so no handshake can
    // land on the same edge that resets the FSM.
    assign bus.req_ready = (state == IDLE) && !reset;

    // Store lane placement from the live request (registered on handshake).
    // funct3[1:0] = 11 falls into the word case; funct3[2] is irrelevant here.
    always_comb begin
        st_mask = 4'b1111;
        st_data = bus.req_wdata;
        case (bus.req_funct3[1:0])
            2'b00: begin
                st_mask = 4'b0001 << bus.req_addr[1:0];
                st_data = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                st_mask = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        mis_req = 1'b0;
        if (bus.req_funct3[1:0] == 2'b01)
            mis_req = bus.req_addr[0];
        else if (bus.req_funct3[1])
            mis_req = (bus.req_addr[1:0] != 2'b00);
    end
`else
    assign mis_req = 1'b0;
    assign mis_q   = 1'b0;
`endif

    // Load formatting uses the address still held on mem_addr from ISSUE.
    always_comb begin
        case (bus.mem_addr[1:0])
            2'd0:    ld_byte = bus.mem_rdata[7:0];
            2'd1:    ld_byte = bus.mem_rdata[15:8];
            2'd2:    ld_byte = bus.mem_rdata[23:16];
            default: ld_byte = bus.mem_rdata[31:24];
        endcase
        ld_half = bus.mem_addr[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (funct3_q[1:0])
            2'b00:   ld_fmt = funct3_q[2] ? {24'b0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            2'b01:   ld_fmt = funct3_q[2] ? {16'b0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_fmt = bus.mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            funct3_q      <= 3'b000;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.mem_rstrb <= 1'b0;
            bus.mem_wmask <= 4'b0000;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_q         <= 1'b0;
`endif
        end else begin
            bus.rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        we_q          <= bus.req_we;
                        funct3_q      <= bus.req_funct3;
                        bus.mem_addr  <= bus.req_addr;
                        bus.mem_wdata <= st_data;
                        bus.mem_rstrb <= !bus.req_we && !mis_req;
                        bus.mem_wmask <= (bus.req_we && !mis_req) ? st_mask : 4'b0000;
`ifdef LSU_MISALIGN_TRAP_EN
                        mis_q         <= mis_req;
`endif
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    bus.mem_rstrb <= 1'b0;
                    bus.mem_wmask <= 4'b0000;
                    // Stores and trapped accesses skip WAIT; no RAM data needed.
                    if (we_q || mis_q) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= '0;
                        bus.rsp_err   <= mis_q;
                        state         <= RESP;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_rdata <= ld_fmt;
                    bus.rsp_err   <= 1'b0;
                    state         <= RESP;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
    localparam int MAXC = 8192;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    load_store_unit_if #(.XLEN(32)) bus ();

    load_store_unit #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 64) return 32'h8000_1234;
        return (32'(i) * 32'h0101_0101) ^ 32'h5A3C_96E1;
    endfunction

    // ---------------- RAM device ----------------
    logic [31:0] ram [0:255];
    bit ram_ready;
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
            ram_ready <= 1'b1;
        end else begin
            if (bus.mem_rstrb) bus.mem_rdata <= ram[bus.mem_addr[9:2]];
            for (int i = 0; i < 4; i++)
                if (bus.mem_wmask[i]) ram[bus.mem_addr[9:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
        end
    end

    // ---------------- reference model ----------------
    function automatic bit misal(input bit [2:0] f3, input bit [31:0] a);
        bit en;
`ifdef LSU_MISALIGN_TRAP_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        return en && (((f3[1:0] == 2'b01) && a[0]) || (f3[1] && (a[1:0] != 2'b00)));
    endfunction

    function automatic logic [31:0] load_val(input bit [2:0] f3, input bit [31:0] a, input logic [31:0] w);
        logic [31:0] b, h;
        b = (w >> (8 * int'(a[1:0]))) & 32'hFF;
        h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
        case (f3[1:0])
            2'b00:   return (f3[2] || b < 128) ? b : (b | 32'hFFFF_FF00);
            2'b01:   return (f3[2] || h < 32768) ? h : (h | 32'hFFFF_0000);
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] store_mask(input bit [2:0] f3, input bit [31:0] a);
        case (f3[1:0])
            2'b00:   return 4'(1 << a[1:0]);
            2'b01:   return a[1] ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input bit [2:0] f3, input bit [31:0] wd);
        case (f3[1:0])
            2'b00:   return 32'(wd[7:0]) * 32'h0101_0101;
            2'b01:   return 32'(wd[15:0]) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    logic [31:0] ref_mem [0:255];
    bit          ref_ready;
    bit          e_valid [0:MAXC-1];
    bit          e_err   [0:MAXC-1];
    bit          e_rstrb [0:MAXC-1];
    bit   [3:0]  e_wmask [0:MAXC-1];
    bit   [31:0] e_addr  [0:MAXC-1];
    bit          e_wdchk [0:MAXC-1];
    bit   [31:0] e_wdata [0:MAXC-1];
    bit          e_rdset [0:MAXC-1];
    bit   [31:0] e_rdata [0:MAXC-1];
    bit          e_zero  [0:MAXC-1];
    int          cyc = 0;
    int          ready_at = 0;
    int          live_from = MAXC;
    logic [31:0] held = 32'h0;

    always @(negedge clk) begin
        int n;
        bit exp_ready;
        bit [2:0] f3;
        bit [31:0] a;
        logic [3:0] m;
        logic [31:0] d;
        n = cyc;
        if (!ref_ready) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
            ref_ready = 1'b1;
        end
        exp_ready = !reset && (n >= ready_at);
        if (reset || n >= live_from)
            chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
        if (n >= live_from && n < MAXC) begin
            if (e_rdset[n]) held = e_rdata[n];
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_valid[n]));
            if (e_valid[n]) chk("rsp_err", 32'(bus.rsp_err), 32'(e_err[n]));
            chk("rsp_rdata", bus.rsp_rdata, held);
            chk("mem_rstrb", 32'(bus.mem_rstrb), 32'(e_rstrb[n]));
            chk("mem_wmask", 32'(bus.mem_wmask), 32'(e_wmask[n]));
            if (e_rstrb[n] || e_wmask[n] != 4'h0) chk("mem_addr", bus.mem_addr, e_addr[n]);
            if (e_wdchk[n]) chk("mem_wdata", bus.mem_wdata, e_wdata[n]);
            if (e_zero[n]) begin
                chk("reset_mem_addr", bus.mem_addr, 32'h0);
                chk("reset_mem_wdata", bus.mem_wdata, 32'h0);
                chk("reset_rsp_err", 32'(bus.rsp_err), 32'h0);
            end
        end
        if (n + 4 < MAXC) begin
            if (reset) begin
                for (int k = n + 1; k <= n + 4; k++) begin
                    e_valid[k] = 0; e_err[k] = 0; e_rstrb[k] = 0; e_wmask[k] = 0;
                    e_wdchk[k] = 0; e_rdset[k] = 0; e_zero[k] = 0;
                end
                e_zero[n+1]  = 1;
                e_rdset[n+1] = 1;
                e_rdata[n+1] = 32'h0;
                ready_at     = n + 1;
                if (live_from > n + 1) live_from = n + 1;
            end else if (bus.req_valid && exp_ready) begin
                f3 = bus.req_funct3;
                a  = bus.req_addr;
                if (misal(f3, a)) begin
                    e_valid[n+2] = 1; e_err[n+2] = 1;
                    e_rdset[n+2] = 1; e_rdata[n+2] = 32'h0;
                    ready_at = n + 3;
                end else if (bus.req_we) begin
                    m = store_mask(f3, a);
                    d = store_data(f3, bus.req_wdata);
                    e_wmask[n+1] = m; e_addr[n+1] = a;
                    e_wdchk[n+1] = 1; e_wdata[n+1] = d;
                    for (int i = 0; i < 4; i++)
                        if (m[i]) ref_mem[a[9:2]][8*i +: 8] = d[8*i +: 8];
                    e_valid[n+2] = 1; e_err[n+2] = 0;
                    e_rdset[n+2] = 1; e_rdata[n+2] = 32'h0;
                    ready_at = n + 3;
                end else begin
                    e_rstrb[n+1] = 1; e_addr[n+1] = a;
                    e_valid[n+3] = 1; e_err[n+3] = 0;
                    e_rdset[n+3] = 1; e_rdata[n+3] = load_val(f3, a, ref_mem[a[9:2]]);
                    ready_at = n + 4;
                end
            end
        end
        cyc++;
    end

    // ---------------- directed + random stimulus ----------------
    task automatic do_req(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic err,
                          output logic [3:0] mask, output logic [31:0] wdat, output logic rstrb);
        int k;
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
        bus.req_addr = a; bus.req_wdata = wd;
        k = 0;
        do begin @(negedge clk); k++; end while (!bus.req_ready && k < 20);
        chk("handshake_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = -1; rd = 32'h0; err = 1'b0; mask = 4'h0; wdat = 32'h0; rstrb = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) begin
                mask = bus.mem_wmask; wdat = bus.mem_wdata; rstrb = bus.mem_rstrb;
            end
            if (bus.rsp_valid && lat < 0) begin
                lat = c; rd = bus.rsp_rdata; err = bus.rsp_err;
            end
        end
    endtask

    initial begin
        int lat, hs;
        logic [31:0] rd, wdat;
        logic err, rstrb;
        logic [3:0] mask;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'b0;
        bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);

        // loads from word 0x8000_1234 at 0x100
        do_req(0, 3'b000, 32'h100, 0, lat, rd, err, mask, wdat, rstrb);
        chk("lb_100", rd, 32'h0000_0034); chk("lb_100_lat", 32'(lat), 32'd3);
        chk("lb_100_rstrb", 32'(rstrb), 32'h1);
        do_req(0, 3'b000, 32'h101, 0, lat, rd, err, mask, wdat, rstrb);
        chk("lb_101", rd, 32'h0000_0012); chk("lb_101_lat", 32'(lat), 32'd3);
        do_req(0, 3'b001, 32'h102, 0, lat, rd, err, mask, wdat, rstrb);
        chk("lh_102", rd, 32'hFFFF_8000); chk("lh_102_lat", 32'(lat), 32'd3);
        do_req(0, 3'b101, 32'h102, 0, lat, rd, err, mask, wdat, rstrb);
        chk("lhu_102", rd, 32'h0000_8000); chk("lhu_102_lat", 32'(lat), 32'd3);

        // stores
        do_req(1, 3'b000, 32'h203, 32'h0000_00AB, lat, rd, err, mask, wdat, rstrb);
        chk("sb_mask", 32'(mask), 32'h8); chk("sb_wdata", wdat, 32'hABAB_ABAB);
        chk("sb_lat", 32'(lat), 32'd2); chk("sb_rdata", rd, 32'h0);
        do_req(1, 3'b001, 32'h202, 32'h0000_BEEF, lat, rd, err, mask, wdat, rstrb);
        chk("sh_mask", 32'(mask), 32'hC); chk("sh_wdata", wdat, 32'hBEEF_BEEF);
        do_req(0, 3'b010, 32'h200, 0, lat, rd, err, mask, wdat, rstrb);
        chk("lw_200_hi", rd >> 16, 32'h0000_BEEF);
        do_req(1, 3'b010, 32'h204, 32'h1234_5678, lat, rd, err, mask, wdat, rstrb);
        chk("sw_mask", 32'(mask), 32'hF); chk("sw_wdata", wdat, 32'h1234_5678);

        // req_valid held for 10 cycles of loads
        @(posedge clk); #1;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'b010; bus.req_addr = 32'h100;
        hs = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.req_ready) hs++;
        end
        @(posedge clk); #1 bus.req_valid = 1'b0;
        chk("held_valid_handshakes", 32'(hs), 32'd3);
        repeat (6) @(posedge clk);

        // reset while in WAIT
        #1 bus.req_valid = 1'b1; bus.req_funct3 = 3'b010; bus.req_addr = 32'h100;
        @(negedge clk);
        chk("pre_reset_ready", 32'(bus.req_ready), 32'h1);
        @(posedge clk); #1 bus.req_valid = 1'b0;     // ISSUE
        @(posedge clk); #1 reset = 1'b1;             // WAIT
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
        chk("rst_rstrb", 32'(bus.mem_rstrb), 32'h0);
        chk("rst_wmask", 32'(bus.mem_wmask), 32'h0);
        chk("rst_addr", bus.mem_addr, 32'h0);
        chk("rst_ready", 32'(bus.req_ready), 32'h1);
        repeat (3) @(posedge clk);

        // misaligned word load
        do_req(0, 3'b010, 32'h101, 0, lat, rd, err, mask, wdat, rstrb);
`ifdef LSU_MISALIGN_TRAP_EN
        chk("lw_101_lat", 32'(lat), 32'd2); chk("lw_101_err", 32'(err), 32'h1);
        chk("lw_101_rstrb", 32'(rstrb), 32'h0); chk("lw_101_rdata", rd, 32'h0);
`else
        chk("lw_101_lat", 32'(lat), 32'd3); chk("lw_101_err", 32'(err), 32'h0);
        chk("lw_101_rdata", rd, 32'h8000_1234);
`endif

        // randomized traffic, including occasional resets
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            reset            = ($urandom_range(99) == 0);
            bus.req_valid    = ($urandom_range(2) != 0);
            bus.req_we       = 1'($urandom_range(1));
            bus.req_funct3   = 3'($urandom_range(7));
            bus.req_addr     = 32'($urandom_range(1023));
            bus.req_wdata    = $urandom;
        end
        @(posedge clk); #1;
        reset = 1'b0; bus.req_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
